// File: rtl/spi_flash_boot_loader.sv
// spi_flash_boot_loader: boot-time copier that streams a ROM image from a
// mode-0 SPI flash (READ 0x03) into CPU memory and holds the CPU in reset.
// Ports: clk, reset (async, active-high), reload (re-run request, DONE only);
//   flash_csb/flash_clk/flash_io_o/flash_io_oe/flash_io_i -> SPI flash pins;
//   wr_valid/wr_ready/wr_addr/wr_data -> memory write port;
//   busy/done/cpu_resb -> progress, cpu_resb releases the CPU when done.
module spi_flash_boot_loader #(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned POR_CYCLES  = 16,
    parameter logic [23:0] FLASH_START = 24'h000000,
    parameter int unsigned IMAGE_BYTES = 16384,
    parameter logic [15:0] DEST_BASE   = 16'hC000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reload,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic [3:0]  flash_io_o,
    output logic [3:0]  flash_io_oe,
    input  logic [3:0]  flash_io_i,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic        cpu_resb
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int POR_W = $clog2(POR_CYCLES) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);
    localparam logic [16:0] IMG_N = 17'(IMAGE_BYTES);
    localparam logic [31:0] READ_CMD = {8'h03, FLASH_START};

    typedef enum logic [2:0] {
        S_POR,
        S_CMD,
        S_DATA,
        S_WRITE,
        S_FINISH,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [POR_W-1:0]   por_q, por_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               sck_q, sck_d;
    logic [31:0]        cmd_q, cmd_d;
    logic [4:0]         bit_q, bit_d;
    logic [7:0]         rx_q, rx_d;
    logic [7:0]         data_q, data_d;
    logic [15:0]        addr_q, addr_d;
    logic [16:0]        cnt_q, cnt_d;

    logic tick;
    logic sck_run;
    logic sck_fall;
    logic last_byte;
    logic miso;
    logic unused_io;

    assign tick      = (div_q == DIV_LAST);
    assign sck_run   = (state_q == S_CMD) || (state_q == S_DATA);
    // Both shifting directions happen on the clk edge that drops SCK.
    assign sck_fall  = sck_run && tick && sck_q;
    assign last_byte = ((cnt_q + 17'd1) == IMG_N);
    assign miso      = flash_io_i[1];
    assign unused_io = ^{flash_io_i[3:2], flash_io_i[0]};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_POR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_POR: begin
                if (por_q == POR_LAST) state_d = S_CMD;
            end
            S_CMD: begin
                if (sck_fall && bit_q == 5'd31) state_d = S_DATA;
            end
            S_DATA: begin
                if (sck_fall && bit_q[2:0] == 3'd7) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (wr_ready) state_d = last_byte ? S_FINISH : S_DATA;
            end
            S_FINISH: begin
                if (tick) state_d = S_DONE;
            end
            S_DONE: begin
                if (reload) state_d = S_POR;
            end
            default: state_d = S_POR;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            por_q  <= '0;
            div_q  <= '0;
            sck_q  <= 1'b0;
            cmd_q  <= '0;
            bit_q  <= '0;
            rx_q   <= '0;
            data_q <= '0;
            addr_q <= DEST_BASE;
            cnt_q  <= '0;
        end else begin
            por_q  <= por_d;
            div_q  <= div_d;
            sck_q  <= sck_d;
            cmd_q  <= cmd_d;
            bit_q  <= bit_d;
            rx_q   <= rx_d;
            data_q <= data_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Datapath next values
    always_comb begin
        por_d  = '0;
        div_d  = '0;
        sck_d  = 1'b0;
        cmd_d  = cmd_q;
        bit_d  = bit_q;
        rx_d   = rx_q;
        data_d = data_q;
        addr_d = addr_q;
        cnt_d  = cnt_q;

        if (state_q == S_POR) por_d = por_q + 1'b1;

        // Divider restarts on every state change so a resumed byte
        // always begins with a full SCK low phase.
        if (state_d == state_q && !tick &&
            (sck_run || state_q == S_FINISH)) begin
            div_d = div_q + 1'b1;
        end

        if (sck_run) sck_d = tick ? ~sck_q : sck_q;

        if (state_q == S_POR && state_d == S_CMD) begin
            cmd_d = READ_CMD;
        end else if (sck_fall) begin
            // Zero fill keeps MOSI low once the command is out.
            cmd_d = {cmd_q[30:0], 1'b0};
        end

        if (state_q == S_POR) begin
            bit_d = '0;
        end else if (sck_fall) begin
            bit_d = (state_d != state_q) ? 5'd0 : bit_q + 5'd1;
        end

        if (sck_fall) rx_d = {rx_q[6:0], miso};

        if (sck_fall && state_d == S_WRITE) data_d = rx_d;

        if (state_q == S_WRITE && wr_ready) begin
            addr_d = addr_q + 16'd1;
            cnt_d  = cnt_q + 17'd1;
        end else if (state_q == S_DONE && reload) begin
            addr_d = DEST_BASE;
            cnt_d  = '0;
        end
    end

    // Outputs
    always_comb begin
        flash_csb   = !((state_q == S_CMD) || (state_q == S_DATA) ||
                        (state_q == S_WRITE));
        flash_clk   = sck_q;
        flash_io_o  = {2'b11, 1'b0, cmd_q[31]};
        flash_io_oe = 4'b1101;
        wr_valid    = (state_q == S_WRITE);
        wr_addr     = addr_q;
        wr_data     = data_q;
        busy        = (state_q != S_DONE);
        done        = (state_q == S_DONE);
        cpu_resb    = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_spi_flash_boot_loader.sv
// tb_spi_flash_boot_loader: random-stimulus bench with a behavioural SPI
// flash and an expected write list built from the flash image.
`timescale 1ns/1ps
module tb_spi_flash_boot_loader;

    localparam int unsigned CLK_DIV     = 2;
    localparam int unsigned POR_CYCLES  = 16;
    localparam logic [23:0] FLASH_START = 24'h100000;
    localparam int unsigned IMAGE_BYTES = 4;
    localparam logic [15:0] DEST_BASE   = 16'hFFFE;
    localparam logic [31:0] READ_CMD    = 32'h0310_0000;
    localparam int unsigned RISES_RUN   = 32 + 8 * IMAGE_BYTES;

    logic        clk = 1'b0;
    logic        reset;
    logic        reload;
    logic        flash_csb;
    logic        flash_clk;
    logic [3:0]  flash_io_o;
    logic [3:0]  flash_io_oe;
    logic [3:0]  flash_io_i;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic        cpu_resb;

    always #5 clk = ~clk;

    spi_flash_boot_loader #(
        .CLK_DIV    (CLK_DIV),
        .POR_CYCLES (POR_CYCLES),
        .FLASH_START(FLASH_START),
        .IMAGE_BYTES(IMAGE_BYTES),
        .DEST_BASE  (DEST_BASE)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .reload     (reload),
        .flash_csb  (flash_csb),
        .flash_clk  (flash_clk),
        .flash_io_o (flash_io_o),
        .flash_io_oe(flash_io_oe),
        .flash_io_i (flash_io_i),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .cpu_resb   (cpu_resb)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural flash: latch the command on rising SCK, then shift the
    // image out MSB-first, changing data on falling SCK.
    logic [7:0]  flash_mem [0:IMAGE_BYTES-1];
    logic [31:0] f_cmd = '0;
    int          f_bits = 0;
    int          f_out = 0;
    logic        miso = 1'b0;
    int          rise_cnt = 0;
    int          csb_falls = 0;
    int          sck_wv = 0;
    int          sck_csb_hi = 0;

    assign flash_io_i = {2'b10, miso, 1'b1};

    always @(negedge flash_csb) begin
        f_cmd  = '0;
        f_bits = 0;
        f_out  = 0;
        csb_falls++;
    end

    always @(posedge flash_clk) begin
        rise_cnt++;
        if (flash_csb) sck_csb_hi++;
        if (wr_valid) sck_wv++;
        if (f_bits < 32) f_cmd = {f_cmd[30:0], flash_io_o[0]};
        f_bits++;
    end

    always @(negedge flash_clk) begin
        int idx;
        if (!flash_csb && f_bits >= 32) begin
            idx = int'(f_cmd[23:0] - FLASH_START) + f_out / 8;
            if (idx >= 0 && idx < int'(IMAGE_BYTES))
                miso = flash_mem[idx][7 - (f_out % 8)];
            else
                miso = 1'b0;
            f_out++;
        end
    end

    // Memory side: drive wr_ready and record accepted writes.
    int          ready_mode = 0;
    int          stall_left = 0;
    logic [15:0] got_addr [$];
    logic [7:0]  got_data [$];
    logic        pv = 1'b0;
    logic [15:0] pa = '0;
    logic [7:0]  pd = '0;

    always @(negedge clk) begin
        if (ready_mode == 0) begin
            wr_ready = 1'b1;
        end else if (ready_mode == 1) begin
            if (wr_valid && got_addr.size() == 1 && stall_left > 0) begin
                wr_ready = 1'b0;
                stall_left--;
                check("stall_addr", wr_addr, DEST_BASE + 16'd1);
                check("stall_data", wr_data, flash_mem[1]);
            end else begin
                wr_ready = 1'b1;
            end
        end else begin
            wr_ready = ($urandom_range(0, 2) != 0);
        end
        if (wr_valid) begin
            check("sck_low_wv", flash_clk, 1'b0);
            if (pv) begin
                check("hold_addr", wr_addr, pa);
                check("hold_data", wr_data, pd);
            end
            if (wr_ready) begin
                got_addr.push_back(wr_addr);
                got_data.push_back(wr_data);
            end
        end
        pv = wr_valid && !wr_ready && !reset;
        pa = wr_addr;
        pd = wr_data;
    end

    task automatic start_run();
        got_addr.delete();
        got_data.delete();
        rise_cnt   = 0;
        csb_falls  = 0;
        sck_wv     = 0;
        sck_csb_hi = 0;
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        check("reload_resb", cpu_resb, 1'b0);
        check("reload_busy", busy, 1'b1);
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic wait_done(string tag);
        int n = 0;
        while (!done && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_done"}, done, 1'b1);
    endtask

    task automatic finish_checks(string tag);
        logic [15:0] ea;
        int          nw;
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_resb"}, cpu_resb, 1'b1);
        check({tag, "_csb"}, flash_csb, 1'b1);
        check({tag, "_sck"}, flash_clk, 1'b0);
        check({tag, "_cmd"}, f_cmd, READ_CMD);
        check({tag, "_nwr"}, got_addr.size(), IMAGE_BYTES);
        nw = (got_addr.size() < IMAGE_BYTES) ? got_addr.size() : IMAGE_BYTES;
        for (int i = 0; i < nw; i++) begin
            ea = DEST_BASE + 16'(i);
            check($sformatf("%s_addr%0d", tag, i), got_addr[i], ea);
            check($sformatf("%s_data%0d", tag, i), got_data[i], flash_mem[i]);
        end
        check({tag, "_rises"}, rise_cnt, RISES_RUN);
        check({tag, "_csbfalls"}, csb_falls, 1);
        check({tag, "_sck_wv"}, sck_wv, 0);
        check({tag, "_sck_csbhi"}, sck_csb_hi, 0);
        repeat (10) @(posedge clk);
        #1;
        check({tag, "_quiet"}, rise_cnt, RISES_RUN);
        check({tag, "_still_done"}, done, 1'b1);
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        reload   = 1'b0;
        wr_ready = 1'b1;
        flash_mem = '{8'hAA, 8'h55, 8'h01, 8'hFE};
        repeat (3) @(posedge clk);
        #1;
        check("rst_csb", flash_csb, 1'b1);
        check("rst_sck", flash_clk, 1'b0);
        check("rst_io", flash_io_o, 4'b1100);
        check("rst_oe", flash_io_oe, 4'b1101);
        check("rst_wv", wr_valid, 1'b0);
        check("rst_addr", wr_addr, DEST_BASE);
        check("rst_data", wr_data, 8'h00);
        check("rst_busy", busy, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_resb", cpu_resb, 1'b0);

        // Run 1: ready tied high, fixed image, timing of CSB and SCK.
        start_run();
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (flash_csb && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("por_cycles", n, POR_CYCLES);
        check("mosi_first", flash_io_o[0], READ_CMD[31]);
        n = 0;
        while (!flash_clk && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("first_rise", n, CLK_DIV);
        n = 0;
        while (flash_clk && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("sck_high", n, CLK_DIV);
        wait_done("r1");
        finish_checks("r1");

        // Run 2: 5-clk stall on the second byte, reload while busy ignored.
        ready_mode = 1;
        stall_left = 5;
        start_run();
        pulse_reload();
        repeat (60) @(posedge clk);
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("busy_reload_resb", cpu_resb, 1'b0);
        wait_done("r2");
        check("r2_stalled", stall_left, 0);
        finish_checks("r2");

        // Run 3: asynchronous reset during the third byte.
        ready_mode = 0;
        start_run();
        pulse_reload();
        n = 0;
        while (!(got_addr.size() == 2 && flash_clk) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("r3_in_byte3", got_addr.size(), 2);
        #2;
        reset = 1'b1;
        #1;
        check("r3_async_csb", flash_csb, 1'b1);
        check("r3_async_sck", flash_clk, 1'b0);
        check("r3_async_wv", wr_valid, 1'b0);
        check("r3_async_resb", cpu_resb, 1'b0);
        check("r3_async_addr", wr_addr, DEST_BASE);
        start_run();
        @(negedge clk);
        reset = 1'b0;
        wait_done("r3");
        finish_checks("r3");

        // Runs 4..9: random image, random ready, random busy reload.
        ready_mode = 2;
        for (int r = 4; r < 10; r++) begin
            for (int b = 0; b < int'(IMAGE_BYTES); b++)
                flash_mem[b] = 8'($urandom);
            start_run();
            pulse_reload();
            repeat ($urandom_range(1, 120)) @(posedge clk);
            @(negedge clk);
            reload = 1'b1;
            @(negedge clk);
            reload = 1'b0;
            wait_done($sformatf("r%0d", r));
            finish_checks($sformatf("r%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
